// File: rtl/adc_sample_averager.sv
// Block averager for flash-converter codes: sums 2^LOG2_N accepted samples and emits sum >> LOG2_N.
// Optional macro ADC_AVG_ROUND_EN selects round-half-up instead of truncation.
module adc_sample_averager #(
    parameter int DATA_W = 8,
    parameter int LOG2_N = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] dig_in,
    input  logic              out_ready,
    output logic [DATA_W-1:0] avg_out,
    output logic              avg_valid,
    output logic              overrun
);

    localparam int ACC_W = DATA_W + LOG2_N;
    localparam logic [LOG2_N-1:0] CNT_ONE = LOG2_N'(1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ACC_W-1:0]    r_acc;
    logic [LOG2_N-1:0]   r_cnt;
    logic [ACC_W-1:0]    w_sum;
    logic                w_done;
    logic [DATA_W-1:0]   w_result;
    logic                w_load;
    logic                w_set_ovr;

    assign w_sum  = r_acc + {{LOG2_N{1'b0}}, dig_in};
    assign w_done = sample_en && (r_cnt == '1);

`ifdef ADC_AVG_ROUND_EN
    localparam logic [ACC_W-1:0] HALF = ACC_W'(1) << (LOG2_N - 1);
    // sum + half stays below 2^ACC_W because the largest sum is N*(2^DATA_W-1)
    logic [ACC_W-1:0] w_rnd;
    assign w_rnd    = w_sum + HALF;
    assign w_result = DATA_W'(w_rnd >> LOG2_N);
`else
    assign w_result = DATA_W'(w_sum >> LOG2_N);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (sample_en) begin
            r_acc <= w_done ? '0 : w_sum;
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_set_ovr   = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_done) begin
                    w_load      = 1'b1;
                    w_state_nxt = FULL;
                end
            end
            FULL: begin
                if (w_done) begin
                    if (out_ready) w_load    = 1'b1;
                    else           w_set_ovr = 1'b1;
                end else if (out_ready) begin
                    w_state_nxt = EMPTY;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            avg_out <= '0;
            overrun <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) avg_out <= w_result;
            if (w_set_ovr) overrun <= 1'b1;
        end
    end

    assign avg_valid = (r_state == FULL);

endmodule

// File: tb/tb_adc_sample_averager.sv
// Directed bench for adc_sample_averager (N=8) with a scoreboard queue of expected block averages.
module tb_adc_sample_averager;

    localparam int DATA_W = 8;
    localparam int LOG2_N = 3;
    localparam int N      = 1 << LOG2_N;
`ifdef ADC_AVG_ROUND_EN
    localparam int HALF_T = N / 2;
`else
    localparam int HALF_T = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sample_en = 1'b0;
    logic [DATA_W-1:0] dig_in = '0;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] avg_out;
    logic              avg_valid;
    logic              overrun;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int mdl_acc = 0;
    int mdl_cnt = 0;
    int last_out = 0;

    adc_sample_averager #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_en (sample_en),
        .dig_in    (dig_in),
        .out_ready (out_ready),
        .avg_out   (avg_out),
        .avg_valid (avg_valid),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle at the falling edge; return 1 time unit after the next rising edge.
    task automatic step(input logic en, input int din, input logic rdy);
        @(negedge clk);
        sample_en = en;
        dig_in    = DATA_W'(din);
        out_ready = rdy;
        if (en) begin
            mdl_acc += din;
            if (mdl_cnt == N - 1) begin
                exp_q.push_back((mdl_acc + HALF_T) >> LOG2_N);
                mdl_acc = 0;
                mdl_cnt = 0;
            end else begin
                mdl_cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_result(input string tag);
        chk({tag, "_valid"}, int'(avg_valid), 1);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s_out observed=%0d expected=<scoreboard empty>", tag, avg_out);
        end else begin
            last_out = exp_q.pop_front();
            chk({tag, "_out"}, int'(avg_out), last_out);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        sample_en = 1'b0;
        out_ready = 1'b0;
        mdl_acc   = 0;
        mdl_cnt   = 0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_out", int'(avg_out), 0);
        chk("rst_valid", int'(avg_valid), 0);
        chk("rst_ovr", int'(overrun), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // eight samples of 100, one-cycle valid with out_ready high
        for (int i = 0; i < N - 1; i++) step(1'b1, 100, 1'b1);
        chk("c100_early_valid", int'(avg_valid), 0);
        step(1'b1, 100, 1'b1);
        chk_result("c100");
        step(1'b0, 0, 1'b1);
        chk("c100_drop_valid", int'(avg_valid), 0);
        chk("c100_hold_out", int'(avg_out), last_out);

        // ramp 0..7 (truncation vs rounding), then full-scale block
        for (int i = 0; i < N; i++) step(1'b1, i, 1'b1);
        chk_result("ramp");
        step(1'b0, 0, 1'b1);
        for (int i = 0; i < N; i++) step(1'b1, 255, 1'b1);
        chk_result("max");
        step(1'b0, 0, 1'b1);

        // overrun: two blocks with no consumer
        for (int i = 0; i < N; i++) step(1'b1, 10, 1'b0);
        chk_result("ovr_b1");
        chk("ovr_b1_flag", int'(overrun), 0);
        for (int i = 0; i < N; i++) step(1'b1, 20, 1'b0);
        void'(exp_q.pop_back());
        chk("ovr_b2_valid", int'(avg_valid), 1);
        chk("ovr_b2_out", int'(avg_out), last_out);
        chk("ovr_b2_flag", int'(overrun), 1);
        step(1'b0, 0, 1'b1);
        chk("ovr_drain_valid", int'(avg_valid), 0);
        chk("ovr_sticky", int'(overrun), 1);
        step(1'b0, 0, 1'b1);
        chk("ovr_sticky2", int'(overrun), 1);

        // completion coinciding with consume while FULL
        do_reset();
        chk("rst2_ovr", int'(overrun), 0);
        for (int i = 0; i < N; i++) step(1'b1, 10, 1'b0);
        chk_result("swap_b1");
        for (int i = 0; i < N - 1; i++) step(1'b1, 40, 1'b0);
        chk("swap_hold_valid", int'(avg_valid), 1);
        step(1'b1, 40, 1'b1);
        chk_result("swap_b2");
        chk("swap_ovr", int'(overrun), 0);

        // asynchronous reset mid-cycle with a partial block pending
        for (int i = 0; i < 5; i++) step(1'b1, 200, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out", int'(avg_out), 0);
        chk("arst_valid", int'(avg_valid), 0);
        chk("arst_ovr", int'(overrun), 0);
        mdl_acc = 0;
        mdl_cnt = 0;
        exp_q.delete();
        @(negedge clk);
        sample_en = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < N - 1; i++) step(1'b1, 50, 1'b1);
        chk("arst_partial_valid", int'(avg_valid), 0);
        step(1'b1, 50, 1'b1);
        chk_result("arst_b50");
        step(1'b0, 0, 1'b1);

        // gapped strobe with ramp 16..128
        for (int i = 1; i <= N; i++) begin
            step(1'b1, 16 * i, 1'b1);
            if (i < N) begin
                chk("gap_valid", int'(avg_valid), 0);
                step(1'b0, 255, 1'b1);
                step(1'b0, 255, 1'b1);
            end
        end
        chk_result("gap");
        step(1'b0, 0, 1'b1);
        chk("gap_drain_valid", int'(avg_valid), 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/adc_sample_averager.md
ADC_SAMPLE_AVERAGER -- requirements
Module: adc_sample_averager

Interface
REQ-001 Parameter DATA_W, default 8, width of the flash converter code consumed and of the averaged result.
REQ-002 Parameter LOG2_N, default 3, log2 of samples per average block (N = 2^LOG2_N), legal range 1..8.
REQ-003 Port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port sample_en  input  1  strobe: dig_in holds a valid converter code this cycle.
REQ-006 Port dig_in  input  DATA_W  unsigned code from the upstream flash_8bit dig_out.
REQ-007 Port out_ready  input  1  downstream accepts avg_out this cycle.
REQ-008 Port avg_out  output  DATA_W  registered block average.
REQ-009 Port avg_valid  output  1  avg_out holds an unconsumed result.
REQ-010 Port overrun  output  1  sticky flag: a completed result was dropped.

Function
REQ-011 Accumulator acc SHALL be DATA_W+LOG2_N bits unsigned; sample counter cnt SHALL be LOG2_N bits; no overflow is possible.
REQ-012 Each cycle with sample_en=1: acc <= acc + dig_in, cnt <= cnt + 1; sample_en=0 leaves acc and cnt unchanged.
REQ-013 When sample_en=1 and cnt = N-1 (block complete): sum = acc + dig_in, acc <= 0, cnt <= 0 (wrap), and a result is produced from sum in the same edge.
REQ-014 Result = sum >> LOG2_N (truncation) unless REQ-023 applies; latency: result visible on avg_out one clock edge after the Nth accepted sample.
REQ-015 Accumulation SHALL continue without pause regardless of output state (no input backpressure; sample_en is never ignored).
REQ-016 Output FSM has two states: EMPTY (avg_valid=0) and FULL (avg_valid=1).
REQ-017 EMPTY + result: load avg_out, go FULL.
REQ-018 FULL + out_ready=1, no result: go EMPTY; avg_out holds last value.
REQ-019 FULL + out_ready=1 + result same cycle: load new avg_out, stay FULL, overrun unchanged.
REQ-020 FULL + out_ready=0 + result: new result discarded, avg_out unchanged, overrun <= 1 and stays 1 until reset.
REQ-021 EMPTY + out_ready=1: no effect; out_ready is don't-care in EMPTY.

Reset
REQ-022 rst_n low SHALL immediately, independent of clk, force acc=0, cnt=0, state EMPTY, avg_valid=0, avg_out=0, overrun=0; a partial block in progress is discarded and the first block after reset release starts at sample 1.

Configuration
REQ-023 Macro ADC_AVG_ROUND_EN: when defined, result = (sum + 2^(LOG2_N-1)) >> LOG2_N (round half up, cannot exceed 2^DATA_W-1); when undefined, plain truncation per REQ-014; all other behaviour identical.

Verification
REQ-024 N=8, eight sample_en pulses with dig_in=100, out_ready=1 -> avg_out=100, avg_valid=1 for exactly one cycle, one edge after 8th sample.
REQ-025 N=8, dig_in=0,1,...,7 -> avg_out=3 without ADC_AVG_ROUND_EN, avg_out=4 with it; eight samples of 255 -> 255 in both builds.
REQ-026 out_ready=0, two full blocks (all 10, then all 20) -> avg_out stays 10, avg_valid stays 1, overrun=1 from the edge completing block 2; then out_ready=1 -> avg_valid falls next edge, overrun remains 1.
REQ-027 Block completion (all 40) in the same cycle as out_ready=1 while FULL with 10 -> avg_out=40, avg_valid stays 1, overrun stays 0.
REQ-028 Five samples of 200, rst_n asserted mid-cycle (between edges) -> all outputs 0 immediately; after release, eight samples of 50 -> avg_out=50.
REQ-029 sample_en gapped (one pulse every 3 cycles, ramp codes 16,32,...,128) -> avg_out=72 after the 8th pulse; idle cycles do not change cnt or acc.
